load_unit_xlen: RTL

- Parametrised load unit that replaces the combinational load-op decode with a full sequential load path.
- Decodes funct3/AMO, issues one or two aligned bus reads, merges, shifts and sign/zero-extends the data, then returns a single response.
- Sits between the multicycle control FSM (load request) and the data-memory bus port; supports RV32 and RV64 load widths.

---
 rtl/load_unit_xlen_if.sv | 24 ++
 rtl/load_unit_xlen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/load_unit_xlen_if.sv
// Data-memory read port between the load unit (master) and the memory (slave).
// Carries the word-aligned read request and its one-cycle completion.
interface load_unit_xlen_if #(
    parameter int XLEN = 32
);
    logic            mem_valid;
    logic            mem_ready;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/load_unit_xlen.sv
// Sequential RV32/RV64 load unit: decode, one or two aligned bus reads, merge, extend.
// Optional feature: LOAD_UNIT_MISALIGNED_SPLIT_EN splits non-AMO misaligned loads.
module load_unit_xlen #(
    parameter int XLEN   = 32,
    parameter int NBYTES = XLEN / 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       funct3,
    input  logic             amo_data_load,
    input  logic [XLEN-1:0]  addr,
    load_unit_xlen_if.master mem,
    output logic             rsp_valid,
    output logic [XLEN-1:0]  rsp_data,
    output logic             rsp_fault
);
    localparam int OFFW  = $clog2(NBYTES);
    localparam int WORDW = XLEN - OFFW;
    localparam bit IS64  = (XLEN == 64);
`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RD0,
        RD1,
        RESP
    } state_t;

    state_t state, next_state;

    logic [3:0]      dec_size;
    logic            dec_signed;
    logic            dec_legal;
    logic            dec_misaligned;
    logic            dec_fault;
    logic [OFFW-1:0] size_mask;
    logic            accept;

    logic [WORDW-1:0] word_q;
    logic [OFFW-1:0]  off_q;
    logic [3:0]       size_q;
    logic             signed_q;
    logic             fault_q;
    logic [XLEN-1:0]  lo_q;
`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
    logic [XLEN-1:0]  hi_q;
    logic [4:0]       span;
    logic             crosses;
`endif

    logic             mem_valid_c;
    logic [XLEN-1:0]  mem_addr_c;
    logic [OFFW+2:0]  shamt;
    logic [XLEN-1:0]  shifted;
    logic             ext_bit;
    logic [XLEN-1:0]  load_result;

    assign accept = req_valid && (state == IDLE);

    // Size and signedness of the incoming request; LD/LWU only exist on RV64.
    always_comb begin
        dec_size   = 4'd0;
        dec_signed = 1'b0;
        dec_legal  = 1'b0;
        if (amo_data_load) begin
            if (funct3 == 3'b010) begin
                dec_size   = 4'd4;
                dec_signed = 1'b1;
                dec_legal  = 1'b1;
            end else if (funct3 == 3'b011 && IS64) begin
                dec_size   = 4'd8;
                dec_signed = 1'b1;
                dec_legal  = 1'b1;
            end
        end else begin
            case (funct3)
                3'b000: begin dec_size = 4'd1; dec_signed = 1'b1; dec_legal = 1'b1; end
                3'b001: begin dec_size = 4'd2; dec_signed = 1'b1; dec_legal = 1'b1; end
                3'b010: begin dec_size = 4'd4; dec_signed = 1'b1; dec_legal = 1'b1; end
                3'b100: begin dec_size = 4'd1; dec_signed = 1'b0; dec_legal = 1'b1; end
                3'b101: begin dec_size = 4'd2; dec_signed = 1'b0; dec_legal = 1'b1; end
                3'b011: begin dec_size = 4'd8; dec_signed = 1'b1; dec_legal = IS64; end
                3'b110: begin dec_size = 4'd4; dec_signed = 1'b0; dec_legal = IS64; end
                default: ;
            endcase
        end
    end

    assign size_mask      = dec_size[OFFW-1:0] - OFFW'(1);
    assign dec_misaligned = dec_legal && ((addr[OFFW-1:0] & size_mask) != '0);
    assign dec_fault      = !dec_legal || (dec_misaligned && (amo_data_load || !SPLIT_EN));

`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
    assign span    = 5'(off_q) + 5'(size_q);
    assign crosses = span > 5'(NBYTES);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_q   <= '0;
            off_q    <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            fault_q  <= 1'b0;
            lo_q     <= '0;
`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
            hi_q     <= '0;
`endif
        end else begin
            if (accept) begin
                word_q   <= addr[XLEN-1:OFFW];
                off_q    <= addr[OFFW-1:0];
                size_q   <= dec_size;
                signed_q <= dec_signed;
                fault_q  <= dec_fault;
            end
            if (state == RD0 && mem.mem_ready) begin
                lo_q <= mem.mem_rdata;
            end
`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
            if (state == RD1 && mem.mem_ready) begin
                hi_q <= mem.mem_rdata;
            end
`endif
        end
    end

    // Bring the addressed byte to bit 0; bytes past the first word come from hi_q.
    assign shamt = {off_q, 3'b000};
`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
    assign shifted = XLEN'({hi_q, lo_q} >> shamt);
`else
    assign shifted = lo_q >> shamt;
`endif

    always_comb begin
        case (size_q)
            4'd1:    ext_bit = shifted[7];
            4'd2:    ext_bit = shifted[15];
            4'd4:    ext_bit = shifted[31];
            default: ext_bit = shifted[XLEN-1];
        endcase
        ext_bit = ext_bit & signed_q;
        load_result = '0;
        for (int i = 0; i < NBYTES; i++) begin
            load_result[8*i +: 8] = (i < int'(size_q)) ? shifted[8*i +: 8] : {8{ext_bit}};
        end
    end

    always_comb begin
        next_state  = state;
        req_ready   = 1'b0;
        mem_valid_c = 1'b0;
        mem_addr_c  = '0;
        rsp_valid   = 1'b0;
        rsp_fault   = 1'b0;
        rsp_data    = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = dec_fault ? RESP : RD0;
                end
            end
            RD0: begin
                mem_valid_c = 1'b1;
                mem_addr_c  = {word_q, {OFFW{1'b0}}};
                if (mem.mem_ready) begin
`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
                    next_state = crosses ? RD1 : RESP;
`else
                    next_state = RESP;
`endif
                end
            end
`ifdef LOAD_UNIT_MISALIGNED_SPLIT_EN
            RD1: begin
                mem_valid_c = 1'b1;
                mem_addr_c  = {word_q + WORDW'(1), {OFFW{1'b0}}};
                if (mem.mem_ready) begin
                    next_state = RESP;
                end
            end
`endif
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_fault  = fault_q;
                rsp_data   = fault_q ? '0 : load_result;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign mem.mem_valid = mem_valid_c;
    assign mem.mem_addr  = mem_addr_c;
endmodule
